cpu_fetch_sequencer: RTL and testbench
======================================

Name: cpu_fetch_sequencer

Overview:
- Sequences the multi-cycle CPU around the combinational instruction decoder.
- Owns the program counter, the instruction register, the execute-phase State bit and the registered N/Z flags.
- Runs instruction fetch from memory over a req/ack handshake, then applies the decoder's PS, IR_L and NS outputs to advance PC and State.
- Sits between instruction memory, the decoder and the ALU flag outputs.

Parameters:
- ADDR_W, 16, PC and memory address width
- RESET_PC, 16'h0000, PC value loaded on reset
- MAX_WAIT, 15, maximum cycles Mem_Ack may lag Mem_Req before a fetch fault

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Mem_Req  out  1  instruction fetch request
- Mem_Addr  out  ADDR_W  fetch address (equals PC)
- Mem_Ack  in  1  fetch data valid this cycle
- Mem_Data  in  16  instruction word
- IR  out  16  instruction register, drives decoder
- State  out  1  execute phase (0 = EX0, 1 = EX1), drives decoder
- PS  in  2  PC control from decoder
- IR_L  in  1  decoder IR-load/advance enable
- NS  in  1  decoder next-state request
- PC_In  in  ADDR_W  absolute target from datapath
- ALU_N  in  1  ALU negative result
- ALU_Z  in  1  ALU zero result
- Flag_L  in  1  latch ALU flags this execute cycle
- N  out  1  registered negative flag, to decoder
- Z  out  1  registered zero flag, to decoder
- PC  out  ADDR_W  program counter
- Halt  in  1  stop issuing new fetches
- Fault  out  1  sticky fetch-timeout indicator
- Exec  out  1  high during execute cycles (datapath write qualifier)

Behaviour:
- Reset, asynchronous, Reset_n=0:
  - PC=RESET_PC; IR=16'h0000; State=0; N=0; Z=0; Fault=0; Mem_Req=0; Exec=0.
  - FSM enters FETCH.
  - Reset mid-fetch or mid-execute aborts immediately; no PC, IR or flag update.
- FSM states: FETCH, WAIT, EXEC, STOP.
- FETCH:
  - If Halt=1 or Fault=1, go to STOP.
  - Else assert Mem_Req=1 with Mem_Addr=PC, clear the wait counter, go to WAIT.
- WAIT:
  - Mem_Req stays 1.
  - On Mem_Ack=1: IR<=Mem_Data, drop Mem_Req the next cycle, State<=0, go to EXEC.
  - Otherwise the wait counter increments. If it reaches MAX_WAIT without an ack: Fault<=1, Mem_Req<=0, go to STOP.
  - An ack that arrives in the same cycle the counter reaches MAX_WAIT wins (normal load, no fault).
- Fetch latency: at least 2 cycles (FETCH, then WAIT with immediate ack).
- EXEC (Exec=1), one cycle per execute phase:
  - Flags: if Flag_L=1, N<=ALU_N and Z<=ALU_Z at the end of the cycle. The decoder sees the old flags this cycle.
  - If NS=1 and State=0: State<=1, PC unchanged, IR unchanged, stay in EXEC (EX1 cycle follows).
  - NS=1 while State=1 is illegal: treat as NS=0 (instruction completes; no third phase).
  - On completion (NS=0): apply PS:
    - 00 hold PC
    - 01 PC<=PC+1
    - 10 PC<=PC+1+sign-extend(IR[7:0])
    - 11 PC<=PC_In
  - All PC arithmetic is modulo 2^ADDR_W (wrap from all-ones to 0, and below 0 to all-ones).
  - After PS is applied, State<=0.
  - If IR_L=1, go to FETCH. If IR_L=0, re-execute the same IR (EXEC again, State=0) without a fetch.
- STOP:
  - Mem_Req=0, Exec=0, all registers hold.
  - Leave to FETCH when Halt=0 and Fault=0.
  - Fault clears only on reset.
- Halt asserted during WAIT or EXEC takes effect at the next FETCH. An in-flight instruction always completes.
- Mem_Ack outside WAIT is ignored.

Test Plan:
- Reset then release, Mem_Ack returned 1 cycle after Mem_Req, Mem_Data=16'h1234, PS=01, IR_L=1, NS=0 -> Mem_Addr=0, IR=16'h1234, one Exec cycle, PC=1, next Mem_Addr=1.
- Two-phase instruction: NS=1 in EX0, NS=0 in EX1, PS=11, PC_In=16'h00A0 -> State 0 then 1, Exec high 2 cycles, PC=16'h00A0, then fetch from 16'h00A0.
- Relative branch: PC=16'h0010, IR[7:0]=8'hFC, PS=10 -> PC=16'h000D. Then PC=16'hFFFF with PS=01 -> PC=16'h0000.
- Flags: Flag_L=1, ALU_Z=1, ALU_N=0 in EXEC -> Z=1 and N=0 the next cycle, old values visible during that EXEC cycle. Flag_L=0 -> flags hold.
- Fetch timeout: Mem_Ack held 0 -> Fault=1 and Mem_Req=0 exactly after MAX_WAIT wait cycles, PC unchanged. Halt toggling does not clear it; Reset_n pulse does.
- Asynchronous reset asserted mid-WAIT and mid-EX1 -> all outputs reach reset values without a clock edge; fetch restarts from RESET_PC after release.

Source files
------------

// File: rtl/cpu_fetch_sequencer.sv
// Multi-cycle CPU sequencer: owns PC, IR, execute-phase bit and N/Z flags,
// fetches over a req/ack handshake and applies decoder PS/IR_L/NS in EXEC.
module cpu_fetch_sequencer #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  output logic              Mem_Req,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic              Mem_Ack,
  input  logic [15:0]       Mem_Data,
  output logic [15:0]       IR,
  output logic              State,
  input  logic [1:0]        PS,
  input  logic              IR_L,
  input  logic              NS,
  input  logic [ADDR_W-1:0] PC_In,
  input  logic              ALU_N,
  input  logic              ALU_Z,
  input  logic              Flag_L,
  output logic              N,
  output logic              Z,
  output logic [ADDR_W-1:0] PC,
  input  logic              Halt,
  output logic              Fault,
  output logic              Exec
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {FETCH, WAIT, EXEC, STOP} fsm_t;

  fsm_t              fsm;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] pc_next;
  logic              complete;

  assign Mem_Addr   = PC;
  assign branch_off = {{(ADDR_W-8){IR[7]}}, IR[7:0]};
  // NS is only honoured in EX0; in EX1 the instruction always completes.
  assign complete   = !(NS && !State);

  always_comb begin
    pc_next = PC;
    case (PS)
      2'b00: pc_next = PC;
      2'b01: pc_next = PC + ADDR_W'(1);
      2'b10: pc_next = PC + ADDR_W'(1) + branch_off;
      2'b11: pc_next = PC_In;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsm      <= FETCH;
      PC       <= RESET_PC;
      IR       <= 16'h0000;
      State    <= 1'b0;
      N        <= 1'b0;
      Z        <= 1'b0;
      Fault    <= 1'b0;
      Mem_Req  <= 1'b0;
      Exec     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (fsm)
        FETCH: begin
          if (Halt || Fault) begin
            fsm <= STOP;
          end else begin
            Mem_Req  <= 1'b1;
            wait_cnt <= '0;
            fsm      <= WAIT;
          end
        end
        WAIT: begin
          // An ack in the last allowed wait cycle still beats the timeout.
          if (Mem_Ack) begin
            IR      <= Mem_Data;
            Mem_Req <= 1'b0;
            State   <= 1'b0;
            Exec    <= 1'b1;
            fsm     <= EXEC;
          end else if (wait_cnt == LAST_WAIT) begin
            Fault   <= 1'b1;
            Mem_Req <= 1'b0;
            fsm     <= STOP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        EXEC: begin
          if (Flag_L) begin
            N <= ALU_N;
            Z <= ALU_Z;
          end
          if (!complete) begin
            State <= 1'b1;
          end else begin
            PC    <= pc_next;
            State <= 1'b0;
            if (IR_L) begin
              Exec <= 1'b0;
              fsm  <= FETCH;
            end
          end
        end
        STOP: begin
          if (!Halt && !Fault) fsm <= FETCH;
        end
        default: fsm <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Bench for cpu_fetch_sequencer: acts as instruction memory and decoder, runs
// directed vectors and corner sequences, then randomized traffic vs a model.
module tb_cpu_fetch_sequencer;

  localparam int MAX_WAIT = 15;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Mem_Req;
  logic [15:0] Mem_Addr;
  logic        Mem_Ack = 1'b0;
  logic [15:0] Mem_Data = 16'h0;
  logic [15:0] IR;
  logic        State;
  logic [1:0]  PS = 2'b00;
  logic        IR_L = 1'b0;
  logic        NS = 1'b0;
  logic [15:0] PC_In = 16'h0;
  logic        ALU_N = 1'b0;
  logic        ALU_Z = 1'b0;
  logic        Flag_L = 1'b0;
  logic        N;
  logic        Z;
  logic [15:0] PC;
  logic        Halt = 1'b0;
  logic        Fault;
  logic        Exec;

  int tests = 0;
  int failed = 0;

  cpu_fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
    .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data), .IR(IR), .State(State), .PS(PS),
    .IR_L(IR_L), .NS(NS), .PC_In(PC_In), .ALU_N(ALU_N), .ALU_Z(ALU_Z),
    .Flag_L(Flag_L), .N(N), .Z(Z), .PC(PC), .Halt(Halt), .Fault(Fault), .Exec(Exec)
  );

  always #5 Clk = ~Clk;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_pc(input logic [15:0] pc, input logic [15:0] ir,
                                           input logic [1:0] ps, input logic [15:0] pin);
    int t;
    case (ps)
      2'd0:    t = int'(pc);
      2'd1:    t = int'(pc) + 1;
      2'd2:    t = int'(pc) + 1 + int'($signed(ir[7:0]));
      default: t = int'(pin);
    endcase
    return t[15:0];
  endfunction

  task automatic wait_req();
    int k = 0;
    while (!Mem_Req && k < 50) begin
      @(negedge Clk);
      k++;
    end
  endtask

  // One complete instruction: immediate ack, then decoder outputs until Exec drops.
  task automatic do_instr(input logic [15:0] word, input logic [1:0] ps, input logic two,
                          input logic ns1, input int reps, input logic [15:0] pin,
                          input logic fl, input logic an, input logic az,
                          output logic [15:0] addr, output int ncyc,
                          output logic n0, output logic z0, output logic [3:0] st_seq);
    int done_cnt = 0;
    addr = 16'hxxxx; ncyc = 0; n0 = 1'b0; z0 = 1'b0; st_seq = 4'b0;
    wait_req();
    if (!Mem_Req) begin
      chkb("req_timeout", Mem_Req, 1'b1);
      return;
    end
    addr = Mem_Addr;
    Mem_Ack = 1'b1; Mem_Data = word;
    @(negedge Clk);
    Mem_Ack = 1'b0; Mem_Data = 16'h0;
    while (Exec && ncyc < 8) begin
      if (ncyc == 0) begin n0 = N; z0 = Z; end
      if (ncyc < 4) st_seq[ncyc] = State;
      PS = ps; PC_In = pin; Flag_L = fl; ALU_N = an; ALU_Z = az;
      NS = State ? ns1 : two;
      IR_L = (done_cnt + 1 >= reps);
      if (!(two && !State)) done_cnt++;
      @(negedge Clk);
      ncyc++;
    end
    PS = 2'b00; NS = 1'b0; IR_L = 1'b0; Flag_L = 1'b0; ALU_N = 1'b0; ALU_Z = 1'b0;
    $display("[TB] instr addr=%04h ir=%04h cycles=%0d pc=%04h N=%b Z=%b", addr, word, ncyc, PC, N, Z);
  endtask

  typedef struct {
    logic [15:0] start;
    logic [15:0] ir;
    logic [15:0] pin;
    logic [1:0]  ps;
    logic        fl, an, az;
    logic [15:0] exp_pc;
    logic        exp_n, exp_z;
  } vec_t;

  vec_t vecs[7];

  logic [15:0] a, pc_before;
  int          nc, cnt;
  logic        n0, z0;
  logic [3:0]  ss;

  logic [15:0] m_pc, m_ir;
  logic        m_n, m_z, m_phase, in_instr, req_seen, ns_v, irl_v, done_v;
  int          m_reps, ack_wait, idle;

  initial begin
    vecs[0] = '{16'h0010, 16'h00FC, 16'h0000, 2'b10, 1'b1, 1'b1, 1'b0, 16'h000D, 1'b1, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 16'h0000, 2'b01, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0001, 16'h00FC, 16'h0000, 2'b10, 1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1};
    vecs[3] = '{16'h1000, 16'h007F, 16'h0000, 2'b10, 1'b0, 1'b1, 1'b1, 16'h1080, 1'b0, 1'b1};
    vecs[4] = '{16'h1234, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1};
    vecs[5] = '{16'h0000, 16'h1180, 16'h0000, 2'b10, 1'b0, 1'b0, 1'b0, 16'hFF81, 1'b0, 1'b1};
    vecs[6] = '{16'h4000, 16'h0000, 16'hBEEF, 2'b11, 1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0};

    repeat (2) @(negedge Clk);
    chkb("rst_req", Mem_Req, 1'b0);
    chkb("rst_exec", Exec, 1'b0);
    chk16("rst_pc", PC, 16'h0000);
    chk16("rst_ir", IR, 16'h0000);
    chkb("rst_state", State, 1'b0);
    chkb("rst_n", N, 1'b0);
    chkb("rst_z", Z, 1'b0);
    chkb("rst_fault", Fault, 1'b0);
    Reset_n = 1'b1;

    // Basic fetch/execute
    do_instr(16'h1234, 2'b01, 1'b0, 1'b0, 1, 16'h0, 1'b0, 1'b0, 1'b0, a, nc, n0, z0, ss);
    chk16("first_addr", a, 16'h0000);
    chk16("first_ir", IR, 16'h1234);
    chk16("first_ncyc", 16'(nc), 16'd1);
    chk16("first_pc", PC, 16'h0001);

    // Two-phase jump
    do_instr(16'h2000, 2'b11, 1'b1, 1'b0, 1, 16'h00A0, 1'b0, 1'b0, 1'b0, a, nc, n0, z0, ss);
    chk16("two_addr", a, 16'h0001);
    chk16("two_ncyc", 16'(nc), 16'd2);
    chk16("two_states", 16'(ss[1:0]), 16'h0002);
    chk16("two_pc", PC, 16'h00A0);

    // NS held high in EX1 must not create a third phase
    do_instr(16'h2800, 2'b01, 1'b1, 1'b1, 1, 16'h0, 1'b0, 1'b0, 1'b0, a, nc, n0, z0, ss);
    chk16("ill_addr", a, 16'h00A0);
    chk16("ill_ncyc", 16'(nc), 16'd2);
    chk16("ill_pc", PC, 16'h00A1);

    // IR_L=0 re-executes the same IR without fetching
    do_instr(16'h4000, 2'b01, 1'b0, 1'b0, 3, 16'h0, 1'b0, 1'b0, 1'b0, a, nc, n0, z0, ss);
    chk16("rep_addr", a, 16'h00A1);
    chk16("rep_ncyc", 16'(nc), 16'd3);
    chk16("rep_pc", PC, 16'h00A4);

    // PC arithmetic and flag latch table
    for (int i = 0; i < 7; i++) begin
      do_instr(16'h0000, 2'b11, 1'b0, 1'b0, 1, vecs[i].start, 1'b0, 1'b0, 1'b0, a, nc, n0, z0, ss);
      do_instr(vecs[i].ir, vecs[i].ps, 1'b0, 1'b0, 1, vecs[i].pin, vecs[i].fl, vecs[i].an,
               vecs[i].az, a, nc, n0, z0, ss);
      chk16($sformatf("vec%0d_addr", i), a, vecs[i].start);
      chk16($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
      chkb($sformatf("vec%0d_n", i), N, vecs[i].exp_n);
      chkb($sformatf("vec%0d_z", i), Z, vecs[i].exp_z);
    end

    // Decoder sees old flags during the latching cycle
    do_instr(16'h0000, 2'b01, 1'b0, 1'b0, 1, 16'h0, 1'b1, 1'b1, 1'b0, a, nc, n0, z0, ss);
    chkb("flag1_old_n", n0, 1'b0);
    chkb("flag1_old_z", z0, 1'b0);
    chkb("flag1_n", N, 1'b1);
    do_instr(16'h0000, 2'b01, 1'b0, 1'b0, 1, 16'h0, 1'b1, 1'b0, 1'b1, a, nc, n0, z0, ss);
    chkb("flag2_old_n", n0, 1'b1);
    chkb("flag2_old_z", z0, 1'b0);
    chkb("flag2_n", N, 1'b0);
    chkb("flag2_z", Z, 1'b1);
    do_instr(16'h0000, 2'b01, 1'b0, 1'b0, 1, 16'h0, 1'b0, 1'b1, 1'b0, a, nc, n0, z0, ss);
    chkb("flag_hold_n", N, 1'b0);
    chkb("flag_hold_z", Z, 1'b1);

    // Ack in the last permitted wait cycle wins over the timeout
    wait_req();
    cnt = 1;
    while (cnt < MAX_WAIT) begin
      @(negedge Clk);
      cnt++;
    end
    chkb("lastwait_req", Mem_Req, 1'b1);
    Mem_Ack = 1'b1; Mem_Data = 16'hABCD;
    @(negedge Clk);
    Mem_Ack = 1'b0;
    chkb("lastwait_fault", Fault, 1'b0);
    chkb("lastwait_exec", Exec, 1'b1);
    chk16("lastwait_ir", IR, 16'hABCD);
    PS = 2'b01; IR_L = 1'b1;
    @(negedge Clk);
    PS = 2'b00; IR_L = 1'b0;
    $display("[TB] late ack at wait cycle %0d, pc=%04h", cnt, PC);

    // Fetch timeout
    wait_req();
    pc_before = PC;
    cnt = 0;
    while (Mem_Req && cnt < 100) begin
      @(negedge Clk);
      cnt++;
    end
    chk16("to_cycles", 16'(cnt), 16'(MAX_WAIT));
    chkb("to_fault", Fault, 1'b1);
    chkb("to_req", Mem_Req, 1'b0);
    chk16("to_pc", PC, pc_before);
    Halt = 1'b1; repeat (3) @(negedge Clk);
    Halt = 1'b0; Mem_Ack = 1'b1; repeat (5) @(negedge Clk);
    Mem_Ack = 1'b0;
    chkb("to_sticky", Fault, 1'b1);
    chkb("to_idle_req", Mem_Req, 1'b0);
    chkb("to_idle_exec", Exec, 1'b0);
    $display("[TB] timeout after %0d wait cycles, pc=%04h", cnt, PC);
    #2 Reset_n = 1'b0;
    #1;
    chkb("to_rst_fault", Fault, 1'b0);
    chk16("to_rst_pc", PC, 16'h0000);
    @(negedge Clk); Reset_n = 1'b1;

    // Asynchronous reset in WAIT
    do_instr(16'h0000, 2'b11, 1'b0, 1'b0, 1, 16'h0300, 1'b0, 1'b0, 1'b0, a, nc, n0, z0, ss);
    wait_req();
    chk16("wrst_addr", Mem_Addr, 16'h0300);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chkb("wrst_req", Mem_Req, 1'b0);
    chk16("wrst_pc", PC, 16'h0000);
    @(negedge Clk); Reset_n = 1'b1;

    // Asynchronous reset in EX1
    do_instr(16'h0000, 2'b11, 1'b0, 1'b0, 1, 16'h0055, 1'b1, 1'b1, 1'b1, a, nc, n0, z0, ss);
    wait_req();
    Mem_Ack = 1'b1; Mem_Data = 16'hBEEF;
    @(negedge Clk);
    Mem_Ack = 1'b0; NS = 1'b1; PS = 2'b11; PC_In = 16'h7777;
    @(negedge Clk);
    chkb("xrst_pre_state", State, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    chkb("xrst_state", State, 1'b0);
    chkb("xrst_exec", Exec, 1'b0);
    chk16("xrst_ir", IR, 16'h0000);
    chk16("xrst_pc", PC, 16'h0000);
    chkb("xrst_n", N, 1'b0);
    chkb("xrst_z", Z, 1'b0);
    @(negedge Clk); Reset_n = 1'b1; NS = 1'b0; PS = 2'b00;
    do_instr(16'h0000, 2'b01, 1'b0, 1'b0, 1, 16'h0, 1'b0, 1'b0, 1'b0, a, nc, n0, z0, ss);
    chk16("xrst_restart_addr", a, 16'h0000);

    // Randomized traffic against an instruction-level model
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    m_pc = 16'h0000; m_ir = 16'h0; m_n = 1'b0; m_z = 1'b0; m_phase = 1'b0;
    in_instr = 1'b0; req_seen = 1'b0; m_reps = 0; ack_wait = 0; idle = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge Clk);
      Mem_Ack = $urandom_range(0, 7) == 0; Mem_Data = 16'($urandom);
      PS = 2'($urandom); NS = 1'($urandom); IR_L = 1'($urandom); PC_In = 16'($urandom);
      Flag_L = 1'($urandom); ALU_N = 1'($urandom); ALU_Z = 1'($urandom);
      if ($urandom_range(0, 59) == 0) Halt = ~Halt;
      if (Exec) begin
        idle = 0;
        chkb("r_exec_after_fetch", in_instr, 1'b1);
        chk16("r_ir", IR, m_ir);
        chkb("r_state", State, m_phase);
        chk16("r_pc", PC, m_pc);
        chkb("r_n", N, m_n);
        chkb("r_z", Z, m_z);
        chkb("r_req_in_exec", Mem_Req, 1'b0);
        ns_v   = m_phase ? m_ir[11] : m_ir[13];
        done_v = !(m_ir[13] && !m_phase);
        irl_v  = m_ir[12] || (m_reps >= 1);
        NS = ns_v; PS = m_ir[15:14]; IR_L = irl_v;
        if (Flag_L) begin m_n = ALU_N; m_z = ALU_Z; end
        if (!done_v) begin
          m_phase = 1'b1;
        end else begin
          m_pc = model_pc(m_pc, m_ir, PS, PC_In);
          m_phase = 1'b0;
          if (irl_v) begin in_instr = 1'b0; m_reps = 0; end
          else m_reps++;
        end
      end else begin
        if (in_instr) begin
          chkb("r_exec_missing", Exec, 1'b1);
          in_instr = 1'b0;
        end
        if (Mem_Req) begin
          idle = 0;
          if (!req_seen) begin
            chk16("r_fetch_addr", Mem_Addr, m_pc);
            req_seen = 1'b1;
            ack_wait = $urandom_range(0, 3);
          end
          if (ack_wait == 0) begin
            m_ir = 16'($urandom);
            Mem_Ack = 1'b1; Mem_Data = m_ir;
            in_instr = 1'b1; m_phase = 1'b0; m_reps = 0; req_seen = 1'b0;
          end else begin
            Mem_Ack = 1'b0;
            ack_wait--;
          end
        end else if (Halt) begin
          idle = 0;
        end else begin
          idle++;
        end
        if (idle > 20) begin
          chkb("r_idle_timeout", Mem_Req | Exec, 1'b1);
          break;
        end
      end
    end
    Halt = 1'b0; Mem_Ack = 1'b0;
    chkb("r_no_fault", Fault, 1'b0);
    $display("[TB] random phase done, model pc=%04h", m_pc);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
